bram_stream_fifo_ctrl: RTL and testbench



---
 rtl/leaf_bram_pkg.sv | 13 +
 rtl/bram_stream_fifo_ctrl_if.sv | 41 ++++
 rtl/bram_rd_skid.sv | 67 ++++++
 rtl/bram_stream_fifo_ctrl.sv | 82 ++++++++
 tb/tb_bram_stream_fifo_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_bram_pkg.sv
// Shared constants for the leaf block-RAM stream FIFO: RAM latency, width limit
// and the occupancy counter width helper.
package leaf_bram_pkg;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int BRAM_MAX_WIDTH  = 36;

    // Occupancy spans RAM depth plus the in-flight read and two buffer slots.
    function automatic int occ_w(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/bram_stream_fifo_ctrl_if.sv
// Bundle of the write stream, read stream and RAM port signals of the stream FIFO.
// The slave modport is the controller's view; master is the surrounding logic.
interface bram_stream_fifo_ctrl_if
    import leaf_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);

    // Handshakes: a word moves on a rising edge where valid and ready are both high;
    // valid never waits for ready, and payload stays stable while valid & !ready.
    logic [DATA_WIDTH-1:0]        in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         mem_ena;
    logic                         mem_wea;
    logic [ADDR_WIDTH-1:0]        mem_addra;
    logic [DATA_WIDTH-1:0]        mem_dina;
    logic                         mem_enb;
    logic [ADDR_WIDTH-1:0]        mem_addrb;
    logic [DATA_WIDTH-1:0]        mem_doutb;
    logic [occ_w(ADDR_WIDTH)-1:0] count;

    modport slave (
        input  in_data, in_valid, out_ready, mem_doutb,
        output in_ready, out_data, out_valid,
        output mem_ena, mem_wea, mem_addra, mem_dina, mem_enb, mem_addrb,
        output count
    );

    modport master (
        output in_data, in_valid, out_ready, mem_doutb,
        input  in_ready, out_data, out_valid,
        input  mem_ena, mem_wea, mem_addra, mem_dina, mem_enb, mem_addrb,
        input  count
    );

endinterface

// File: rtl/bram_rd_skid.sv
// Two-entry output buffer that captures the RAM read word one cycle after issue
// and presents it on a valid/ready stream from entry 0.
module bram_rd_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rd_issue,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    output logic                  o_inflight,
    output logic [1:0]            o_buf_count
);

    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_count;
    logic                  r_inflight;

    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;
    logic [1:0]            w_count_nxt;

    assign w_pop = (r_count != 2'd0) && i_out_ready;

    // Shift first, then land the returning read word in the first free slot.
    always_comb begin
        w_buf0_nxt  = r_buf0;
        w_buf1_nxt  = r_buf1;
        w_count_nxt = r_count;
        if (w_pop) begin
            w_buf0_nxt  = r_buf1;
            w_count_nxt = r_count - 2'd1;
        end
        if (r_inflight) begin
            if (w_count_nxt == 2'd0) begin
                w_buf0_nxt = i_rd_data;
            end else begin
                w_buf1_nxt = i_rd_data;
            end
            w_count_nxt = w_count_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
            r_count    <= w_count_nxt;
            r_inflight <= i_rd_issue;
        end
    end

    assign o_out_data  = r_buf0;
    assign o_out_valid = (r_count != 2'd0);
    assign o_inflight  = r_inflight;
    assign o_buf_count = r_count;

endmodule

// File: rtl/bram_stream_fifo_ctrl.sv
// Stream FIFO controller over a true-dual-port block RAM: port A writes, port B
// prefetches into a 2-entry buffer that hides the 1-cycle read latency.
module bram_stream_fifo_ctrl
    import leaf_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    bram_stream_fifo_ctrl_if.slave  bus
);

    localparam int                  OW      = occ_w(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;

    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic       w_inflight;
    logic       w_out_valid;
    logic [1:0] w_buf_count;
    logic [2:0] w_pending;

    assign bus.in_ready = !reset && (r_ram_count != DEPTH_W);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = w_out_valid && bus.out_ready;

    // Words already headed for the buffer once this cycle's pop is taken out;
    // a new read is only issued if a slot will be free when it returns.
    assign w_pending = {1'b0, w_buf_count} + {2'b00, w_inflight} - {2'b00, w_pop};
    assign w_issue   = !reset && (r_ram_count != '0) && (w_pending < 3'd2);

    assign bus.mem_ena   = w_push;
    assign bus.mem_wea   = w_push;
    assign bus.mem_addra = r_wr_ptr;
    assign bus.mem_dina  = bus.in_data;
    assign bus.mem_enb   = w_issue;
    assign bus.mem_addrb = r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_issue})
                2'b10:   r_ram_count <= r_ram_count + 1'b1;
                2'b01:   r_ram_count <= r_ram_count - 1'b1;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    bram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_rd_issue  (w_issue),
        .i_rd_data   (bus.mem_doutb),
        .i_out_ready (bus.out_ready),
        .o_out_data  (bus.out_data),
        .o_out_valid (w_out_valid),
        .o_inflight  (w_inflight),
        .o_buf_count (w_buf_count)
    );

    assign bus.out_valid = w_out_valid;
    assign bus.count     = OW'(r_ram_count) + OW'(w_inflight) + OW'(w_buf_count);

endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// Bench for bram_stream_fifo_ctrl: behavioural RAM, queue-based reference model
// checked every cycle, and directed plus randomized stream sequences.
module tb_bram_stream_fifo_ctrl;
    import leaf_bram_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bram_stream_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_stream_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural dual-port RAM, 1-cycle read, contents survive reset
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_ena && bus.mem_wea) ram[bus.mem_addra] <= bus.mem_dina;
        if (bus.mem_enb) bus.mem_doutb <= ram[bus.mem_addrb];
    end

    // Scoreboard
    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            wr_total = 0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] hold_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted word is owed to the output in order, and the
    // reported occupancy is simply accepted minus delivered since reset.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_mem_ena", bus.mem_ena, 0);
            check("rst_mem_enb", bus.mem_enb, 0);
            exp_q.delete();
            wr_total  = 0;
            hold_prev = 1'b0;
        end else begin
            check("count", bus.count, exp_q.size());
            if (exp_q.size() < DEPTH) check("in_ready_room", bus.in_ready, 1);
            if (exp_q.size() == DEPTH + 2) check("in_ready_full", bus.in_ready, 0);
            if (exp_q.size() == 0) check("empty_no_valid", bus.out_valid, 0);
            if (hold_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, hold_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("pop_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("pop_data", bus.out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                check("push_wea", {bus.mem_ena, bus.mem_wea}, 2'b11);
                check("push_addr", bus.mem_addra, wr_total % DEPTH);
                check("push_din", bus.mem_dina, bus.in_data);
                exp_q.push_back(bus.in_data);
                wr_total++;
            end else begin
                check("no_write", bus.mem_wea, 0);
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (bus.count == 0 && !bus.out_valid) break;
        end
        check("drain_empty", bus.count, 0);
        tick();
    endtask

    // Offer sequential words base, base+1, ... for 530 cycles with no reads.
    task automatic fill_full(input logic [DW-1:0] base, output int acc);
        bit a;
        acc           = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = base;
        for (int c = 0; c < 530; c++) begin
            @(negedge clk);
            a = bus.in_ready;
            tick();
            if (a) begin
                acc++;
                bus.in_data = base + acc;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int acc, pushed, pops, first, last;
        bit a;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("init_count", bus.count, 0);
        check("init_valid", bus.out_valid, 0);
        check("init_data", bus.out_data, 0);
        check("init_in_ready", bus.in_ready, 1);
        tick();

        // Single word fall-through
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5A5_0001;
        @(negedge clk);
        check("sw_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sw_lat_edge1", bus.out_valid, 0);
        tick();
        @(negedge clk);
        check("sw_lat_edge2", bus.out_valid, 0);
        tick();
        @(negedge clk);
        check("sw_lat_valid", bus.out_valid, 1);
        check("sw_data", bus.out_data, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        check("sw_count_back", bus.count, 0);
        tick();

        // Fill to full, then drain in order
        fill_full(32'd0, acc);
        @(negedge clk);
        check("fill_accepted", acc, DEPTH + 2);
        check("fill_count", bus.count, DEPTH + 2);
        check("fill_in_ready", bus.in_ready, 0);
        tick();
        drain();

        // Streaming, 1 word per cycle after initial latency
        pushed = 0; pops = 0; first = -1; last = -1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        for (int c = 0; c < 2200; c++) begin
            @(negedge clk);
            a = bus.in_valid && bus.in_ready;
            if (pushed < 2000) check("stream_in_ready", bus.in_ready, 1);
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                if (pops == 1) first = c;
                if (pops == 2000) last = c;
            end
            tick();
            if (a) begin
                pushed++;
                if (pushed == 2000) bus.in_valid = 1'b0;
                else bus.in_data = $urandom;
            end
            if (pops == 2000) break;
        end
        check("stream_pops", pops, 2000);
        check("stream_latency", first, 3);
        check("stream_gapless", last - first, 1999);
        drain();

        // Random backpressure
        pushed = 0;
        bus.in_data = $urandom;
        for (int c = 0; c < 60000 && pushed < 10000; c++) begin
            bus.in_valid  = $urandom_range(0, 1);
            bus.out_ready = $urandom_range(0, 1);
            @(negedge clk);
            a = bus.in_valid && bus.in_ready;
            tick();
            if (a) begin
                pushed++;
                bus.in_data = $urandom;
            end
        end
        check("rand_pushed", pushed, 10000);
        drain();

        // Push and pop together at count = 1
        bus.out_ready = 1'b0;
        push_one(32'h1111_0001);
        repeat (3) tick();
        @(negedge clk);
        check("sim1_count", bus.count, 1);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1111_0002;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("sim1_push_pop", {bus.in_ready, bus.out_valid}, 2'b11);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("sim1_count_after", bus.count, 1);
        tick();
        drain();

        // Push while empty with a read in flight
        bus.out_ready = 1'b1;
        push_one(32'h2222_0001);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("inflight_count", bus.count, 1);
        check("inflight_no_valid", bus.out_valid, 0);
        push_one(32'h2222_0002);
        drain();

        // Push and pop together at count = DEPTH+2
        fill_full(32'h3000_0000, acc);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h3FFF_FFFF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("full_push_pop", {bus.in_ready, bus.out_valid}, 2'b01);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("full_count_after", bus.count, DEPTH + 1);
        check("full_in_ready_after", bus.in_ready, 1);
        tick();
        drain();

        // Reset mid-operation with a read in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_one(32'h5000_0000 + i);
        repeat (4) tick();
        @(negedge clk);
        check("mid_count", bus.count, 10);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        check("mid_inflight_count", bus.count, 9);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        tick();
        bus.out_ready = 1'b0;
        push_one(32'h0000_0042);
        a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                a = 1'b1;
                break;
            end
            tick();
        end
        check("post_rst_valid", a, 1);
        check("post_rst_first", bus.out_data, 32'h0000_0042);
        tick();
        drain();

        // Final report
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
